// File: rtl/console_fifo_tb.sv
// Memory-mapped console sink for simulation top-levels: CPU bytes go into a TX FIFO
// that drains at a fixed rate to an observable byte stream and, optionally, to $write.
module console_fifo_tb #(
    parameter int FIFO_DEPTH    = 16,
    parameter int DRAIN_CYCLES  = 4,
    parameter int STALL_ON_FULL = 1,
    parameter int ECHO          = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          drain_en;
    logic [31:0]   total;
    logic [TW-1:0] timer;

    logic [1:0]  reg_sel;
    logic        full;
    logic        empty;
    logic        is_data;
    logic        data_stall;
    logic        accept;
    logic        wr_acc;
    logic        push;
    logic        ovf_set;
    logic        stat_wr;
    logic        ctrl_wr;
    logic        clear;
    logic        pop;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign reg_sel = i_address[3:2];
    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign is_data = (reg_sel == 2'd0);

    // A DATA write against a full FIFO is never accepted in stall mode; the decision
    // uses registered fullness, so a pop on the same edge does not let it through.
    assign data_stall = i_request && i_rw && is_data && full && (STALL_ON_FULL != 0);
    assign accept     = i_request && !o_ready && !data_stall;
    assign wr_acc     = accept && i_rw;
    assign push       = wr_acc && is_data && !full;
    assign ovf_set    = wr_acc && is_data && full;
    assign stat_wr    = wr_acc && (reg_sel == 2'd1);
    assign ctrl_wr    = wr_acc && (reg_sel == 2'd2);
    assign clear      = ctrl_wr && i_wdata[1];
    assign pop        = drain_en && !empty && (timer == '0) && !clear;

    assign unused_bits = ^{i_address[31:4], i_address[1:0], i_wdata[31:8]};

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            2'd1:    rd_val = {16'h0, 8'(count), 5'h0, overflow, empty, full};
            2'd2:    rd_val = {31'h0, drain_en};
            2'd3:    rd_val = total;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr] <= i_wdata[7:0];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_ready    <= 1'b0;
            o_rdata    <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drain_en   <= 1'b1;
            total      <= '0;
            timer      <= RELOAD;
        end else begin
            o_ready    <= accept;
            o_rdata    <= (accept && !i_rw) ? rd_val : '0;
            o_tx_valid <= pop;
            if (pop) begin
                o_tx_data <= mem[rd_ptr];
                total     <= total + 32'd1;
            end

            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end

            // Timer only runs while there is something to drain.
            if (clear || !drain_en || empty || (timer == '0)) begin
                timer <= RELOAD;
            end else begin
                timer <= timer - TW'(1);
            end

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (stat_wr && i_wdata[2]) begin
                overflow <= 1'b0;
            end

            if (ctrl_wr) begin
                drain_en <= i_wdata[0];
            end
        end
    end

    if (ECHO != 0) begin : g_echo
        always_ff @(posedge i_clock) begin
            if (!i_reset && pop) begin
                $write("%s", mem[rd_ptr]);
            end
        end
    end

endmodule
